// File: rtl/mem_access_unit.sv
// Memory-stage bus controller: registers one load/store, drives a stable bus request, returns extended data.
// Define MEM_MISALIGN_SPLIT_EN to make misaligned accesses legal (split into up to two bus beats).
module mem_access_unit #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2:0]          req_size,
    input  logic                req_unsigned,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                req_ready,
    input  logic                flush,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_error,
    output logic [3:0]          resp_code,
    output logic                busy,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [2:0]          dreq_size,
    output logic [DATA_W/8-1:0] dreq_strobe,
    output logic [DATA_W-1:0]   dreq_data,
    input  logic                dresp_data_ok,
    input  logic [DATA_W-1:0]   dresp_data
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam logic [3:0] CODE_LOAD  = 4'd4;
    localparam logic [3:0] CODE_STORE = 4'd6;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t           state;
    logic             op_write;
    logic             op_unsigned;
    logic [2:0]       op_size;
    logic [OFF_W-1:0] op_off;
    logic             flushed;
    logic             resp_pending;
    logic             resp_err_q;

    logic [OFF_W-1:0]  acc_off;
    logic [OFF_W-1:0]  align_mask;
    logic              acc_size_ok;
    logic              acc_mis;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        acc_dsize;
    logic [LANES-1:0]  acc_strobe;
    logic [DATA_W-1:0] acc_data;
    logic [DATA_W-1:0] load_raw;

`ifdef MEM_MISALIGN_SPLIT_EN
    logic [2*LANES-1:0]  wide_strobe;
    logic [2*DATA_W-1:0] wide_data;
    logic [LANES-1:0]    acc_hi_strobe;
    logic [DATA_W-1:0]   acc_hi_data;
    logic                acc_cross;
    logic                op_cross;
    logic [LANES-1:0]    hi_strobe_q;
    logic [DATA_W-1:0]   hi_data_q;
    logic [DATA_W-1:0]   beat0_q;
    logic                split_next;
`endif

    // Truncate to 8<<size bits, then sign- or zero-extend to the full bus width.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                                 input logic [2:0] size,
                                                 input logic uns);
        logic [DATA_W-1:0] res;
        logic              sign;
        int                nbits;
        nbits = 8 << size;
        sign  = 1'b0;
        res   = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (i == nbits - 1) sign = raw[i];
        end
        for (int i = 0; i < int'(DATA_W); i++) begin
            res[i] = (i < nbits) ? raw[i] : (sign & ~uns);
        end
        return res;
    endfunction

    // Decode of the offered request: legality, bus address/size, lane-shifted strobe and data.
    always_comb begin
        acc_off     = req_addr[OFF_W-1:0];
        align_mask  = OFF_W'((32'd1 << req_size) - 32'd1);
        acc_size_ok = (req_size <= 3'(OFF_W));
        acc_mis     = |(acc_off & align_mask);
        acc_addr    = req_addr;
        acc_dsize   = req_size;
`ifdef MEM_MISALIGN_SPLIT_EN
        wide_strobe   = (2*LANES)'((32'd1 << (32'd1 << req_size)) - 32'd1) << acc_off;
        wide_data     = {{DATA_W{1'b0}}, req_wdata} << {acc_off, 3'b000};
        acc_cross     = |wide_strobe[2*LANES-1:LANES];
        acc_strobe    = req_write ? wide_strobe[LANES-1:0] : '0;
        acc_data      = req_write ? wide_data[DATA_W-1:0] : '0;
        acc_hi_strobe = req_write ? wide_strobe[2*LANES-1:LANES] : '0;
        acc_hi_data   = req_write ? wide_data[2*DATA_W-1:DATA_W] : '0;
        acc_err       = ~acc_size_ok;
        if (acc_mis) begin
            acc_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            acc_dsize = 3'(OFF_W);
        end
`else
        acc_strobe = req_write ? (LANES'((32'd1 << (32'd1 << req_size)) - 32'd1) << acc_off) : '0;
        acc_data   = req_write ? (req_wdata << {acc_off, 3'b000}) : '0;
        acc_err    = ~acc_size_ok | acc_mis;
`endif
    end

    // Load lanes realigned to bit 0; a boundary-crossing load merges the first beat below the second.
    always_comb begin
`ifdef MEM_MISALIGN_SPLIT_EN
        if (state == BEAT1) begin
            load_raw = DATA_W'({dresp_data, beat0_q} >> {op_off, 3'b000});
        end else begin
            load_raw = dresp_data >> {op_off, 3'b000};
        end
        split_next = (state == BEAT0) && op_cross && !flushed && !flush;
`else
        load_raw = dresp_data >> {op_off, 3'b000};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_write     <= 1'b0;
            op_unsigned  <= 1'b0;
            op_size      <= '0;
            op_off       <= '0;
            flushed      <= 1'b0;
            resp_pending <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_code    <= '0;
            resp_rdata   <= '0;
            dreq_valid   <= 1'b0;
            dreq_addr    <= '0;
            dreq_size    <= '0;
            dreq_strobe  <= '0;
            dreq_data    <= '0;
`ifdef MEM_MISALIGN_SPLIT_EN
            op_cross     <= 1'b0;
            hi_strobe_q  <= '0;
            hi_data_q    <= '0;
            beat0_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        op_write    <= req_write;
                        op_unsigned <= req_unsigned;
                        op_size     <= req_size;
                        op_off      <= acc_off;
                        flushed     <= 1'b0;
                        if (acc_err) begin
                            state        <= RESP;
                            resp_pending <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_code    <= req_write ? CODE_STORE : CODE_LOAD;
                            resp_rdata   <= '0;
                        end else begin
                            state       <= BEAT0;
                            dreq_valid  <= 1'b1;
                            dreq_addr   <= acc_addr;
                            dreq_size   <= acc_dsize;
                            dreq_strobe <= acc_strobe;
                            dreq_data   <= acc_data;
`ifdef MEM_MISALIGN_SPLIT_EN
                            op_cross    <= acc_cross;
                            hi_strobe_q <= acc_hi_strobe;
                            hi_data_q   <= acc_hi_data;
`endif
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    // A flush never aborts a beat; it only drops the response once the beat is done.
                    if (flush) flushed <= 1'b1;
                    if (dresp_data_ok) begin
                        dreq_valid  <= 1'b0;
                        dreq_addr   <= '0;
                        dreq_size   <= '0;
                        dreq_strobe <= '0;
                        dreq_data   <= '0;
                        flushed     <= 1'b0;
                        if (flushed || flush) begin
                            state <= IDLE;
                        end else begin
                            state        <= RESP;
                            resp_pending <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_code    <= '0;
                            resp_rdata   <= op_write ? '0 : extend(load_raw, op_size, op_unsigned);
                        end
`ifdef MEM_MISALIGN_SPLIT_EN
                        if (split_next) begin
                            state        <= BEAT1;
                            resp_pending <= 1'b0;
                            resp_rdata   <= '0;
                            dreq_valid   <= 1'b1;
                            dreq_addr    <= dreq_addr + ADDR_W'(LANES);
                            dreq_size    <= dreq_size;
                            dreq_strobe  <= hi_strobe_q;
                            dreq_data    <= hi_data_q;
                            beat0_q      <= dresp_data;
                        end
`endif
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    resp_pending <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_code    <= '0;
                    resp_rdata   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = ~reset & (state == IDLE) & req_valid & ~flush;
    assign busy       = (state != IDLE);
    assign resp_valid = resp_pending & ~flush;
    assign resp_error = resp_err_q & ~flush;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level reference model; also honours MEM_MISALIGN_SPLIT_EN.
module tb_mem_access_unit;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 64;
    localparam int L = 8;
`ifdef MEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_write, req_unsigned, req_ready, flush;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_error, busy, dreq_valid, dresp_data_ok;
    logic [DW-1:0] resp_rdata, dreq_data, dresp_data;
    logic [3:0]    resp_code;
    logic [AW-1:0] dreq_addr;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .req_ready(req_ready), .flush(flush),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .resp_code(resp_code), .busy(busy), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    // Expectations for the current cycle, written by the driver just after each rising edge.
    logic        e_ready, e_busy, e_dreq, e_resp, e_write, e_err;
    logic [63:0] e_addr, e_data, e_rdata;
    logic [2:0]  e_size;
    logic [7:0]  e_strobe;
    logic [3:0]  e_code;

    int          n_resp = 0;
    int          n_dreq = 0;
    logic [63:0] last_rdata, last_data;
    logic [3:0]  last_code;
    logic        last_err;
    logic [7:0]  last_strobe;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] bmask(input logic [7:0] s);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Single compare process: every output checked against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("req_ready", 64'(req_ready), 64'(e_ready));
            check("busy", 64'(busy), 64'(e_busy));
            check("dreq_valid", 64'(dreq_valid), 64'(e_dreq));
            if (e_dreq) begin
                check("dreq_addr", dreq_addr, e_addr);
                check("dreq_size", 64'(dreq_size), 64'(e_size));
                check("dreq_strobe", 64'(dreq_strobe), 64'(e_strobe));
                if (e_write) check("dreq_data", dreq_data & bmask(e_strobe), e_data & bmask(e_strobe));
            end
            check("resp_valid", 64'(resp_valid), 64'(e_resp));
            if (e_resp) begin
                check("resp_error", 64'(resp_error), 64'(e_err));
                check("resp_code", 64'(resp_code), 64'(e_code));
                check("resp_rdata", resp_rdata, e_rdata);
            end
        end
        if (resp_valid) begin
            n_resp++;
            last_rdata = resp_rdata;
            last_code  = resp_code;
            last_err   = resp_error;
        end
        if (dreq_valid) begin
            n_dreq++;
            last_strobe = dreq_strobe;
            last_data   = dreq_data;
        end
    end

    task automatic set_idle_exp();
        e_ready = 1'b0; e_busy = 1'b0; e_dreq = 1'b0; e_resp = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        for (int c = 0; c < k; c++) begin
            req_valid = 1'b0; flush = 1'b0;
            dresp_data_ok = ($urandom_range(0, 3) == 0);
            dresp_data = rnd64();
            set_idle_exp();
            @(posedge clk); #1;
        end
        dresp_data_ok = 1'b0;
    endtask

    // Garbage on the request port while busy; it must never be accepted.
    task automatic busy_inputs(input bit f);
        flush = f;
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr = rnd64();
        req_size = 3'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_wdata = rnd64();
        e_ready = 1'b0; e_busy = 1'b1;
    endtask

    // One operation: offer, accept, play the bus, and check the response cycle by cycle.
    task automatic run_op(input bit w, input logic [63:0] a, input logic [2:0] sz, input bit u,
                          input logic [63:0] wd, input int flush_at, input int fwait,
                          input bit use_fd, input logic [63:0] fd0, input logic [63:0] fd1);
        int off, n, nb, idx, waits, p;
        bit mis, err, killed, f, first_flush;
        logic [63:0] baddr[2];
        logic [63:0] bexp[2];
        logic [63:0] rd[2];
        logic [7:0]  bstb[2];
        logic [2:0]  bsz;
        logic [63:0] res;

        off = int'(a[2:0]);
        n = 1 << sz;
        mis = (a & 64'(n - 1)) != 64'd0;
        err = mis && !SPLIT;
        nb = (mis && (off + n > L)) ? 2 : 1;
        for (int b = 0; b < 2; b++) begin
            bstb[b] = 8'h00; bexp[b] = 64'd0; rd[b] = 64'd0;
        end
        for (int i = 0; i < n; i++) begin
            p = off + i;
            if (w) begin
                bstb[p / L][p % L] = 1'b1;
                bexp[p / L][8*(p % L) +: 8] = wd[8*i +: 8];
            end
        end
        if (!mis) begin
            baddr[0] = a; baddr[1] = a; bsz = sz;
        end else begin
            baddr[0] = a & ~64'(L - 1); baddr[1] = baddr[0] + 64'(L); bsz = 3'd3;
        end

        // Offer; occasionally with flush held, which must block acceptance.
        first_flush = ($urandom_range(0, 5) == 0);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
        req_unsigned = u; req_wdata = wd;
        dresp_data_ok = ($urandom_range(0, 3) == 0); dresp_data = rnd64();
        flush = first_flush;
        set_idle_exp();
        e_ready = !first_flush;
        @(posedge clk); #1;
        if (first_flush) begin
            flush = 1'b0; e_ready = 1'b1; dresp_data_ok = 1'b0;
            @(posedge clk); #1;
        end
        dresp_data_ok = 1'b0;
        idx = 1;
        killed = 1'b0;

        if (err) begin
            f = (idx == flush_at); killed = killed | f;
            busy_inputs(f);
            dresp_data_ok = ($urandom_range(0, 1) == 0); dresp_data = rnd64();
            e_dreq = 1'b0; e_resp = !killed; e_err = 1'b1;
            e_code = w ? 4'd6 : 4'd4; e_rdata = 64'd0;
            @(posedge clk); #1; idx++;
        end else begin
            for (int b = 0; b < nb; b++) begin
                waits = (fwait >= 0) ? fwait : $urandom_range(0, 3);
                for (int wc = 0; wc <= waits; wc++) begin
                    f = (idx == flush_at); killed = killed | f;
                    busy_inputs(f);
                    e_dreq = 1'b1; e_resp = 1'b0; e_write = w;
                    e_addr = baddr[b]; e_size = bsz; e_strobe = bstb[b]; e_data = bexp[b];
                    dresp_data_ok = (wc == waits);
                    dresp_data = use_fd ? ((b == 0) ? fd0 : fd1) : rnd64();
                    if (wc == waits) rd[b] = dresp_data;
                    @(posedge clk); #1; idx++;
                end
                dresp_data_ok = 1'b0;
                if (killed) break;
            end
            if (!killed) begin
                f = (idx == flush_at); killed = killed | f;
                busy_inputs(f);
                dresp_data_ok = ($urandom_range(0, 1) == 0); dresp_data = rnd64();
                res = 64'd0;
                if (!w) begin
                    for (int i = 0; i < n; i++) begin
                        p = off + i;
                        res[8*i +: 8] = rd[p / L][8*(p % L) +: 8];
                    end
                    if (!u && res[8*n - 1]) begin
                        for (int j = 8*n; j < 64; j++) res[j] = 1'b1;
                    end
                end
                e_dreq = 1'b0; e_resp = !killed; e_err = 1'b0; e_code = 4'd0; e_rdata = res;
                @(posedge clk); #1; idx++;
            end
        end
        req_valid = 1'b0; flush = 1'b0; dresp_data_ok = 1'b0;
        set_idle_exp();
    endtask

    int r0, d0;
    logic [63:0] ra;
    logic [2:0]  rs;

    initial begin
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; flush = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        set_idle_exp();
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset dreq_valid", 64'(dreq_valid), 64'd0);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset dreq_strobe", 64'(dreq_strobe), 64'd0);
        check("reset resp_rdata", resp_rdata, 64'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #1;

        // Aligned signed word load, data_ok three cycles after the request.
        r0 = n_resp;
        run_op(1'b0, 64'h8000_0004, 3'd2, 1'b0, 64'd0, 0, 2, 1'b1, 64'h8000_0001_dead_beef, 64'd0);
        check("aligned load rdata", last_rdata, 64'hFFFF_FFFF_8000_0001);
        check("aligned load resp count", 64'(n_resp - r0), 64'd1);

        // Store half at offset 6 with a five-cycle stall.
        run_op(1'b1, 64'h0000_1006, 3'd1, 1'b0, 64'h1234_5678_9abc_beef, 0, 5, 1'b0, 64'd0, 64'd0);
        check("store half strobe", 64'(last_strobe), 64'hC0);
        check("store half lanes", 64'(last_data[63:48]), 64'hBEEF);

`ifndef MEM_MISALIGN_SPLIT_EN
        d0 = n_dreq;
        run_op(1'b0, 64'h0000_1002, 3'd2, 1'b0, 64'd0, 0, -1, 1'b0, 64'd0, 64'd0);
        check("misaligned load code", 64'(last_code), 64'd4);
        check("misaligned load error", 64'(last_err), 64'd1);
        run_op(1'b1, 64'h0000_1002, 3'd2, 1'b0, rnd64(), 0, -1, 1'b0, 64'd0, 64'd0);
        check("misaligned store code", 64'(last_code), 64'd6);
        check("misaligned no bus", 64'(n_dreq - d0), 64'd0);
`else
        d0 = n_dreq;
        run_op(1'b0, 64'h0000_100C, 3'd3, 1'b0, 64'd0, 0, 1, 1'b1,
               64'h4433_2211_0000_0000, 64'h0000_0000_8877_6655);
        check("split load rdata", last_rdata, 64'h8877_6655_4433_2211);
        check("split beat cycles", 64'(n_dreq - d0), 64'd4);
`endif

        // Flush in BEAT0, data_ok two cycles later: beat completes, no response.
        r0 = n_resp;
        run_op(1'b0, 64'h0000_2000, 3'd3, 1'b1, 64'd0, 1, 2, 1'b0, 64'd0, 64'd0);
        check("flush no resp", 64'(n_resp - r0), 64'd0);
        check("flush busy low", 64'(busy), 64'd0);
        r0 = n_resp;
        run_op(1'b0, 64'h0000_2008, 3'd0, 1'b1, 64'd0, 0, 0, 1'b1, 64'h0000_0000_0000_0080, 64'd0);
        check("after flush accept", 64'(n_resp - r0), 64'd1);
        check("byte unsigned", last_rdata, 64'h80);

        // Reset asserted mid-beat.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h100; req_size = 3'd3;
        set_idle_exp(); e_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        e_ready = 1'b0; e_busy = 1'b1; e_dreq = 1'b1; e_write = 1'b0;
        e_addr = 64'h100; e_size = 3'd3; e_strobe = 8'h00;
        @(negedge clk); #2;
        chk_on = 1'b0;
        req_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("mid reset dreq_valid", 64'(dreq_valid), 64'd0);
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset resp_valid", 64'(resp_valid), 64'd0);
        check("mid reset req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        set_idle_exp();
        chk_on = 1'b1;
        idle_cycles(1);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            rs = 3'($urandom_range(0, 3));
            ra = rnd64();
            if ($urandom_range(0, 1) == 0) ra = ra & ~((64'd1 << rs) - 64'd1);
            run_op(1'($urandom_range(0, 1)), ra, rs, 1'($urandom_range(0, 1)), rnd64(),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0,
                   -1, 1'b0, 64'd0, 64'd0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        idle_cycles(3);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage bus controller that replaces the combinational memory stage. It accepts one load/store per handshake from execute and registers the request. It holds the data-bus request stable until `data_ok`, then returns aligned, sign/zero-extended load data or a store completion. Alignment faults are flagged as exception codes 4 (load) and 6 (store); optionally, misaligned accesses are split into two bus beats.

## Interface
Parameters:
- DATA_W, 64, bus data width in bits; legal values 32, 64
- ADDR_W, 64, address width in bits

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  execute presents a memory op
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  3  0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned  in  1  zero-extend the load result
- req_wdata  in  DATA_W  store data, right-aligned
- req_ready  out  1  op accepted this cycle
- flush  in  1  kill the in-flight or offered op
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_error  out  1  exception raised
- resp_code  out  4  4 = load misaligned, 6 = store misaligned
- busy  out  1  state ≠ IDLE
- dreq_valid  out  1  bus request
- dreq_addr  out  ADDR_W  bus address
- dreq_size  out  3  bus size
- dreq_strobe  out  DATA_W/8  byte enables; 0 on loads
- dreq_data  out  DATA_W  lane-shifted store data
- dresp_data_ok  in  1  bus beat complete
- dresp_data  in  DATA_W  bus read data

## Operation
- States: IDLE, BEAT0, BEAT1 (split only), RESP.
- IDLE:
  - `req_ready = req_valid & ~flush`.
  - On accept, latch the request.
  - Compute `off = addr[log2(DATA_W/8)-1:0]` and `n = 1<<size`.
  - Misaligned: `addr % n ≠ 0`. Illegal: `size = 3` with DATA_W = 32.
  - Illegal, or misaligned without split → RESP with error.
  - Otherwise → BEAT0.
- BEAT0/BEAT1:
  - `dreq_valid = 1`.
  - `dreq_addr`, `dreq_size`, `dreq_strobe` and `dreq_data` are constant until `dresp_data_ok`.
  - Store strobe = bytes [off, off+n) of the word; data = `wdata << 8*off`.
- Aligned access: `dreq_addr = req_addr`, `dreq_size = req_size`. On `data_ok` in BEAT0 → RESP.
- Load extract: `(dresp_data >> 8*off)` truncated to n bytes, then sign-extended or, if `req_unsigned`, zero-extended to DATA_W.
- Flush:
  - In BEAT0/BEAT1 the bus beat is not aborted: the beat completes, then the unit returns to IDLE without `resp_valid`.
  - In RESP, `resp_valid` is suppressed.
  - A store already in BEAT1 still completes its second beat.
- RESP: `resp_valid = 1` for one cycle → IDLE. Outputs are held registered during RESP only; they are 0 otherwise.
- `resp_error` and `dreq_valid` are never high for the same op.

## Timing
- Reset (async): state IDLE; every output 0.
- Accept at cycle N; `dreq_valid` high from N+1.
- `data_ok` at cycle M ≥ N+1; `resp_valid` at M+1. Best-case load-to-result is 2 cycles.
- Error path: `resp_valid` and `resp_error` at N+1; no bus activity.
- `req_ready` is 0 whenever `busy`. Back-to-back ops are accepted no sooner than the cycle after RESP.
- `data_ok` is ignored when `dreq_valid` = 0.
- Reset asserted mid-beat: state is lost immediately. The bus is required to tolerate request withdrawal on reset.

## Configuration
- MEM_MISALIGN_SPLIT_EN
  - Defined: a misaligned access is legal.
    - If `off + n ≤ DATA_W/8`: one beat, `dreq_size = log2(DATA_W/8)`, aligned address, shifted strobe/data.
    - If it crosses the boundary: BEAT0 at `addr & ~(DATA_W/8-1)` carries the low bytes (upper lanes); BEAT1 at that address `+ DATA_W/8` carries the high bytes (lower lanes).
    - Load result is merged from both beats before extension. `resp_valid` follows BEAT1's `data_ok` by one cycle.
  - Undefined: every misaligned access returns code 4 or 6, and BEAT1 logic is absent.

## Test plan
- Aligned load: DATA_W = 64, addr 0x80000004, size 2, signed, `dresp_data = 0x8000_0001_xxxx_xxxx`, `data_ok` 3 cycles after the request → single beat, `resp_rdata = 0xFFFF_FFFF_8000_0001`, `resp_valid` 1 cycle after `data_ok`.
- Store half: addr 0x...06, wdata 0xBEEF → `dreq_strobe = 0xC0`, `dreq_data[63:48] = 0xBEEF`; request fields stable across 5 stall cycles.
- Misaligned without the macro: load word at 0x...02 → `resp_error = 1`, `resp_code = 4`, no `dreq_valid`. Store at the same address → `resp_code = 6`.
- Split with the macro: load dword at 0x...0C, first beat returns 0x4433_2211_xxxx_xxxx, second returns 0xxxxx_xxxx_8877_6655 → two beats at 0x...08 and 0x...10, `resp_rdata = 0x8877_6655_4433_2211`.
- Flush in BEAT0 with `data_ok` 2 cycles later → the beat completes, no `resp_valid`, `busy` falls, and the next `req_valid` is accepted.
- Reset asserted in BEAT0 → `dreq_valid`, `busy` and `resp_valid` all 0 asynchronously.
